// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key matrix scanner: FSM states, event record
// and the grid cell index used by both the scanner and the game array.
package key_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EMIT,
        NEXT
    } scan_state_t;

    localparam int KEY_INDEX_W = 8;

    typedef struct packed {
        logic [KEY_INDEX_W-1:0] index;
        logic                   press;
    } key_event_t;

    function automatic int cell_index(input int n, input int row, input int col);
        return n * row + col;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: keeps the last DEBOUNCE samples and the accepted (stable)
// state, and flags a change once the whole history disagrees with that state.
module key_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample,
    input  logic i_accept,
    input  logic i_row,
    output logic o_change,
    output logic o_next_state,
    output logic o_state
);

    logic [DEBOUNCE-1:0] r_hist;
    logic [DEBOUNCE-1:0] w_hist_shift;
    logic [DEBOUNCE-1:0] w_hist_eff;
    logic                r_stable;

    generate
        if (DEBOUNCE == 1) begin : g_single
            assign w_hist_shift = i_row;
        end else begin : g_multi
            assign w_hist_shift = {r_hist[DEBOUNCE-2:0], i_row};
        end
    endgenerate

    // During the sample strobe the change flag already reflects the incoming
    // sample, so the scanner can pick EMIT or NEXT on that same edge.
    assign w_hist_eff   = i_sample ? w_hist_shift : r_hist;
    assign o_change     = r_stable ? ~|w_hist_eff : &w_hist_eff;
    assign o_next_state = ~r_stable;
    assign o_state      = r_stable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hist   <= '0;
            r_stable <= 1'b0;
        end else begin
            if (i_sample) begin
                r_hist <= w_hist_shift;
            end
            if (i_accept && o_change) begin
                r_stable <= ~r_stable;
            end
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-scanned push-button matrix reader: drives one column at a time, debounces
// every key and streams press/release events over a valid/ready handshake.
module key_matrix_scanner
    import key_scan_pkg::*;
#(
    parameter int N             = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int DEBOUNCE      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    output logic [N-1:0]            cols,
    input  logic [N-1:0]            rows_in,
    output logic [N*N-1:0]          pressed,
    output logic                    event_valid,
    input  logic                    event_ready,
    output logic [$clog2(N*N)-1:0]  event_index,
    output logic                    event_press
);

    localparam int IW = $clog2(N*N);
    localparam int CW = $clog2(N);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    w_col_next;
    logic [SW-1:0]    r_settle;
    logic [SW-1:0]    w_settle_next;

    logic [N*N-1:0]   w_change;
    logic [N*N-1:0]   w_next_state;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_sel;
    logic [CW-1:0]    w_sel_row;
    logic [IW-1:0]    w_sel_idx;

    // Pending changes of the column under scan, one bit per row.
    always_comb begin
        w_mask = '0;
        for (int r = 0; r < N; r++) begin
            w_mask[r] = w_change[N*r + int'(r_col)];
        end
    end

    always_comb begin
        w_sel_row = '0;
        for (int r = N - 1; r >= 0; r--) begin
            if (w_mask[r]) begin
                w_sel_row = CW'(r);
            end
        end
    end

    assign w_sel     = N'(1) << w_sel_row;
    assign w_sel_idx = IW'(cell_index(N, int'(w_sel_row), int'(r_col)));

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                localparam int IDX = N*gi + gj;
                logic w_hit;
                logic w_sample;
                logic w_accept;

                assign w_hit    = (r_col == CW'(gj));
                assign w_sample = (r_state == SAMPLE) && w_hit;
                assign w_accept = (r_state == EMIT) && event_ready && w_sel[gi] && w_hit;

                key_debounce #(
                    .DEBOUNCE(DEBOUNCE)
                ) u_key (
                    .clk          (clk),
                    .rst          (rst),
                    .i_sample     (w_sample),
                    .i_accept     (w_accept),
                    .i_row        (rows_in[gi]),
                    .o_change     (w_change[IDX]),
                    .o_next_state (w_next_state[IDX]),
                    .o_state      (pressed[IDX])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_next;
            r_col    <= w_col_next;
            r_settle <= w_settle_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_col_next    = r_col;
        w_settle_next = r_settle;
        cols          = '0;
        event_valid   = 1'b0;
        event_index   = '0;
        event_press   = 1'b0;

        case (r_state)
            IDLE: begin
                w_col_next = '0;
                if (ena) begin
                    w_state_next  = SETTLE;
                    w_settle_next = '0;
                end
            end
            SETTLE: begin
                cols = N'(1) << r_col;
                if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                    w_state_next = SAMPLE;
                end else begin
                    w_settle_next = r_settle + SW'(1);
                end
            end
            SAMPLE: begin
                cols         = N'(1) << r_col;
                w_state_next = (w_mask != '0) ? EMIT : NEXT;
            end
            EMIT: begin
                cols        = N'(1) << r_col;
                event_valid = 1'b1;
                event_index = w_sel_idx;
                event_press = w_next_state[w_sel_idx];
                if (w_mask == '0) begin
                    w_state_next = NEXT;
                end else if (event_ready && ((w_mask & ~w_sel) == '0)) begin
                    w_state_next = NEXT;
                end
            end
            NEXT: begin
                w_settle_next = '0;
                if (ena) begin
                    w_state_next = SETTLE;
                    w_col_next   = (r_col == CW'(N - 1)) ? '0 : r_col + CW'(1);
                end else begin
                    w_state_next = IDLE;
                    w_col_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_col_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a behavioural key matrix feeds rows_in from the
// driven column, and an event scoreboard checks every accepted handshake.
module tb_key_matrix_scanner;
    import key_scan_pkg::*;

    localparam int N      = 5;
    localparam int SETTLE = 4;
    localparam int DEB    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ena = 1'b0;
    logic             event_ready = 1'b0;
    logic [N-1:0]     cols;
    logic [N-1:0]     rows_in;
    logic [N*N-1:0]   pressed;
    logic             event_valid;
    logic [4:0]       event_index;
    logic             event_press;

    logic [N*N-1:0]   key_down = '0;
    logic [N-1:0]     drive_col = '0;

    int               n_checks = 0;
    int               n_pass = 0;
    key_event_t       exp_q[$];

    typedef struct {
        int         k;
        logic [4:0] cols;
        logic       valid;
    } scan_vec_t;
    scan_vec_t vecs[8];

    key_matrix_scanner #(
        .N             (N),
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE      (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .cols        (cols),
        .rows_in     (rows_in),
        .pressed     (pressed),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_index (event_index),
        .event_press (event_press)
    );

    always #5 clk = ~clk;

    // The matrix keeps presenting the last driven column's keys.
    always @(cols) begin
        if (cols != '0) drive_col = cols;
    end

    always_comb begin
        rows_in = '0;
        for (int r = 0; r < N; r++) begin
            rows_in[r] = |(key_down[N*r +: N] & drive_col);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic press);
        key_event_t e;
        e.index = 8'(idx);
        e.press = press;
        exp_q.push_back(e);
    endtask

    task automatic wait_cols_enter(input logic [4:0] v);
        int n;
        n = 0;
        while (cols == v && n < 200) begin tick(); n++; end
        while (cols != v && n < 200) begin tick(); n++; end
        check($sformatf("wait_cols_%b", v), 32'(cols), 32'(v));
    endtask

    always @(negedge clk) begin : monitor
        key_event_t e;
        if (rst && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                check("event_unexpected_index", 32'(event_index), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("event_index", 32'(event_index), 32'(e.index));
                check("event_press", 32'(event_press), 32'(e.press));
            end
            $display("event accepted: index=%0d press=%0d", event_index, event_press);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        vecs[0] = '{0,  5'b00001, 1'b0};
        vecs[1] = '{3,  5'b00001, 1'b0};
        vecs[2] = '{6,  5'b00010, 1'b0};
        vecs[3] = '{12, 5'b00100, 1'b0};
        vecs[4] = '{18, 5'b01000, 1'b0};
        vecs[5] = '{24, 5'b10000, 1'b0};
        vecs[6] = '{30, 5'b00001, 1'b0};
        vecs[7] = '{33, 5'b00001, 1'b0};

        // Reset then enable, scan timing from the vector table
        repeat (5) tick();
        check("reset_cols", 32'(cols), 0);
        check("reset_pressed", 32'(pressed), 0);
        check("reset_valid", 32'(event_valid), 0);
        check("reset_index", 32'(event_index), 0);
        check("reset_press", 32'(event_press), 0);
        rst = 1'b1;
        ena = 1'b1;
        event_ready = 1'b1;
        tick();
        k = 0;
        for (int i = 0; i < 8; i++) begin
            while (k < vecs[i].k) begin tick(); k++; end
            check($sformatf("scan_cols_k%0d", vecs[i].k), 32'(cols), 32'(vecs[i].cols));
            check($sformatf("scan_valid_k%0d", vecs[i].k), 32'(event_valid), 32'(vecs[i].valid));
        end

        // Single press of row 2 / col 3
        wait_cols_enter(5'b10000);
        key_down[13] = 1'b1;
        push_exp(13, 1'b1);
        repeat (3) wait_cols_enter(5'b01000);
        repeat (4) tick();
        check("press_valid_at_sample", 32'(event_valid), 0);
        tick();
        check("press_valid", 32'(event_valid), 1);
        check("press_index", 32'(event_index), 13);
        check("press_cols", 32'(cols), 32'(5'b01000));
        tick();
        check("press_pressed13", 32'(pressed[13]), 1);
        check("press_valid_after", 32'(event_valid), 0);
        repeat (60) tick();
        check("press_hold_queue", 32'(exp_q.size()), 0);
        check("press_hold_pressed", 32'(pressed), 32'(1 << 13));

        // Release key 13
        wait_cols_enter(5'b10000);
        key_down[13] = 1'b0;
        push_exp(13, 1'b0);
        repeat (3) wait_cols_enter(5'b01000);
        repeat (4) tick();
        check("release_valid_at_sample", 32'(event_valid), 0);
        tick();
        check("release_valid", 32'(event_valid), 1);
        check("release_index", 32'(event_index), 13);
        check("release_press", 32'(event_press), 0);
        tick();
        check("release_pressed13", 32'(pressed[13]), 0);

        // Bounce on row 0 / col 0: alternates every scan
        for (int s = 0; s < 10; s++) begin
            wait_cols_enter(5'b00100);
            key_down[0] = ~key_down[0];
        end
        repeat (30) tick();
        check("bounce_pressed", 32'(pressed), 0);
        check("bounce_queue", 32'(exp_q.size()), 0);

        // Simultaneous presses on col 0 with backpressure
        event_ready = 1'b0;
        wait_cols_enter(5'b00100);
        key_down[5]  = 1'b1;
        key_down[20] = 1'b1;
        push_exp(5, 1'b1);
        push_exp(20, 1'b1);
        repeat (3) wait_cols_enter(5'b00001);
        repeat (5) tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_valid_%0d", i), 32'(event_valid), 1);
            check($sformatf("stall_index_%0d", i), 32'(event_index), 5);
            check($sformatf("stall_cols_%0d", i), 32'(cols), 32'(5'b00001));
            tick();
        end
        event_ready = 1'b1;
        tick();
        check("b2b_valid", 32'(event_valid), 1);
        check("b2b_index", 32'(event_index), 20);
        check("b2b_pressed5", 32'(pressed[5]), 1);
        tick();
        check("b2b_valid_done", 32'(event_valid), 0);
        check("b2b_pressed20", 32'(pressed[20]), 1);

        // Disable during SETTLE of col 2
        wait_cols_enter(5'b00100);
        ena = 1'b0;
        repeat (3) tick();
        check("disable_col2_completes", 32'(cols), 32'(5'b00100));
        repeat (3) tick();
        check("disable_idle_cols", 32'(cols), 0);
        repeat (10) tick();
        check("disable_idle_stays", 32'(cols), 0);
        check("disable_idle_valid", 32'(event_valid), 0);
        ena = 1'b1;
        tick();
        check("reenable_col0", 32'(cols), 32'(5'b00001));

        // Reset while an event is pending
        key_down[16] = 1'b1;
        event_ready = 1'b0;
        repeat (3) wait_cols_enter(5'b00010);
        repeat (4) tick();
        check("pend_valid_at_sample", 32'(event_valid), 0);
        tick();
        check("pend_valid", 32'(event_valid), 1);
        check("pend_index", 32'(event_index), 16);
        check("pend_press", 32'(event_press), 1);
        rst = 1'b0;
        tick();
        check("rst_valid", 32'(event_valid), 0);
        check("rst_index", 32'(event_index), 0);
        check("rst_cols", 32'(cols), 0);
        check("rst_pressed", 32'(pressed), 0);
        tick();
        rst = 1'b1;
        ena = 1'b0;
        event_ready = 1'b1;
        repeat (40) tick();
        check("post_rst_valid", 32'(event_valid), 0);
        check("post_rst_cols", 32'(cols), 0);
        check("post_rst_pressed", 32'(pressed), 0);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
